// File: rtl/control_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes,
// sequencer states and the execute-class grouping of instructions.
package control_pkg;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                         OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                         OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8,
                         OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11,
                         OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14,
                         OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17,
                         OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20,
                         OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23,
                         OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26,
                         OP_HALT = 5'd27;

  // T-states share their step number in the low bits so the sequencer can
  // compare directly against the decoder's last-step index.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RESET = 4'd8, S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_HALT, CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV,
    CL_NEGNOT, CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO
  } iclass_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps an opcode to its execute class and the T-step index on which that
// class finishes (2 means no execute steps at all).
module instr_class_decode
  import control_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output logic [2:0] last_step
);

  always_comb begin
    iclass = CL_NOP;
    case (opcode)
      OP_LD:   iclass = CL_LD;
      OP_LDI:  iclass = CL_LDI;
      OP_ST:   iclass = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
               iclass = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:
               iclass = CL_IMM;
      OP_MUL, OP_DIV: iclass = CL_MULDIV;
      OP_NEG, OP_NOT: iclass = CL_NEGNOT;
      OP_BR:   iclass = CL_BR;
      OP_JR:   iclass = CL_JR;
      OP_JAL:  iclass = CL_JAL;
      OP_IN:   iclass = CL_IN;
      OP_OUT:  iclass = CL_OUT;
      OP_MFHI: iclass = CL_MFHI;
      OP_MFLO: iclass = CL_MFLO;
      OP_HALT: iclass = CL_HALT;
      default: iclass = CL_NOP;
    endcase
  end

  always_comb begin
    last_step = 3'd2;
    case (iclass)
      CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: last_step = 3'd3;
      CL_JAL, CL_NEGNOT:                      last_step = 3'd4;
      CL_ALU, CL_IMM, CL_LDI:                 last_step = 3'd5;
      CL_MULDIV, CL_BR:                       last_step = 3'd6;
      CL_LD, CL_ST:                           last_step = 3'd7;
      default:                                last_step = 3'd2;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: shared fetch T0-T2, per-class execute steps,
// and the run/halt state. All datapath strobes are Moore-decoded.
module control_unit
  import control_pkg::*;
#(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] ALU_ADD = 5'b00011
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    IR,
  input  logic           CON_ff,
  input  logic           Stop,
  output logic           R_out, HI_out, LO_out, Zhi_out, Zlo_out,
  output logic           PC_out, MDR_out, In_out, C_out, BAout,
  output logic           MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd,
  output logic           PC_rd, HI_rd, LO_rd, Out_rd, Rin, CONin,
  output logic           Gra, Grb, Grc,
  output logic           IncPC, Read, Write,
  output logic [OPW-1:0] op_sel,
  output logic           Run
);

  state_t     state, next;
  iclass_t    iclass;
  logic [2:0] last_step;
  logic       unused_ir_fields;

  assign unused_ir_fields = ^IR[26:0];

  instr_class_decode u_decode (
    .opcode    (IR[31:27]),
    .iclass    (iclass),
    .last_step (last_step)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_RESET;
    else      state <= next;
  end

  // The last step of every class is the instruction boundary where Stop is honoured.
  always_comb begin
    next = state;
    case (state)
      S_RESET: next = S_T0;
      S_HALT:  next = S_HALT;
      default: begin
        if (state[2:0] == last_step)
          next = (iclass == CL_HALT || Stop) ? S_HALT : S_T0;
        else
          next = state_t'(state + 4'd1);
      end
    endcase
  end

  assign Run = (state != S_RESET) && (state != S_HALT);

  always_comb begin
    {R_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, In_out, C_out, BAout} = '0;
    {MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, PC_rd, HI_rd, LO_rd, Out_rd, Rin, CONin} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write} = '0;
    op_sel = '0;
    case (state)
      S_T0: begin PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1; Zlo_rd = 1'b1; end
      S_T1: begin Zlo_out = 1'b1; PC_rd = 1'b1; Read = 1'b1; MDR_rd = 1'b1; end
      S_T2: begin MDR_out = 1'b1; IR_rd = 1'b1; end
      S_T3: begin
        case (iclass)
          CL_ALU, CL_IMM:      begin Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Y_rd = 1'b1; end
          CL_MULDIV:           begin Gra = 1'b1; R_out = 1'b1; Y_rd = 1'b1; end
          CL_NEGNOT: begin Grb = 1'b1; R_out = 1'b1; op_sel = IR[31 -: OPW]; Zlo_rd = 1'b1; end
          CL_BR:   begin Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; end
          CL_JR:   begin Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1; end
          CL_JAL:  begin PC_out = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          CL_IN:   begin In_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_OUT:  begin Gra = 1'b1; R_out = 1'b1; Out_rd = 1'b1; end
          CL_MFHI: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MFLO: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          CL_ALU: begin Grc = 1'b1; R_out = 1'b1; op_sel = IR[31 -: OPW]; Zlo_rd = 1'b1; end
          CL_IMM: begin C_out = 1'b1; op_sel = IR[31 -: OPW]; Zlo_rd = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin C_out = 1'b1; op_sel = ALU_ADD; Zlo_rd = 1'b1; end
          CL_MULDIV: begin
            Grb = 1'b1; R_out = 1'b1; op_sel = IR[31 -: OPW]; Zlo_rd = 1'b1; Zhi_rd = 1'b1;
          end
          CL_NEGNOT: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_BR:     begin PC_out = 1'b1; Y_rd = 1'b1; end
          CL_JAL:    begin Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          CL_ALU, CL_IMM, CL_LDI: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_LD, CL_ST: begin Zlo_out = 1'b1; MAR_rd = 1'b1; end
          CL_MULDIV:    begin Zlo_out = 1'b1; LO_rd = 1'b1; end
          CL_BR:        begin C_out = 1'b1; op_sel = ALU_ADD; Zlo_rd = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          CL_LD:     begin Read = 1'b1; MDR_rd = 1'b1; end
          CL_ST:     begin Gra = 1'b1; R_out = 1'b1; MDR_rd = 1'b1; end
          CL_MULDIV: begin Zhi_out = 1'b1; HI_rd = 1'b1; end
          CL_BR:     begin Zlo_out = CON_ff; PC_rd = CON_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          CL_LD: begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a latency/T3 vector table, directed
// corner sequences, and a random opcode stream checked against microprograms.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, CON_ff, Stop;
  logic [31:0] IR;
  logic R_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, In_out, C_out, BAout;
  logic MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, PC_rd, HI_rd, LO_rd, Out_rd, Rin, CONin;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0] op_sel;

  int checks = 0;
  int errors = 0;
  int reads, writes;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_ff(CON_ff), .Stop(Stop),
    .R_out(R_out), .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PC_out(PC_out), .MDR_out(MDR_out), .In_out(In_out), .C_out(C_out), .BAout(BAout),
    .MAR_rd(MAR_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .Zlo_rd(Zlo_rd),
    .Zhi_rd(Zhi_rd), .PC_rd(PC_rd), .HI_rd(HI_rd), .LO_rd(LO_rd), .Out_rd(Out_rd),
    .Rin(Rin), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .IncPC(IncPC), .Read(Read), .Write(Write), .op_sel(op_sel), .Run(Run)
  );

  logic [27:0] act;
  logic [33:0] got;
  assign act = {Write, Read, IncPC, Grc, Grb, Gra, CONin, Rin, Out_rd, LO_rd, HI_rd, PC_rd,
                Zhi_rd, Zlo_rd, Y_rd, IR_rd, MDR_rd, MAR_rd, BAout, C_out, In_out, MDR_out,
                PC_out, Zlo_out, Zhi_out, LO_out, HI_out, R_out};
  assign got = {Run, op_sel, act};

  localparam logic [27:0] M_R_OUT = 28'h1 << 0,  M_HI_OUT = 28'h1 << 1,  M_LO_OUT = 28'h1 << 2,
    M_ZHI_OUT = 28'h1 << 3,  M_ZLO_OUT = 28'h1 << 4,  M_PC_OUT = 28'h1 << 5,
    M_MDR_OUT = 28'h1 << 6,  M_IN_OUT = 28'h1 << 7,   M_C_OUT = 28'h1 << 8,
    M_BAOUT = 28'h1 << 9,    M_MAR_RD = 28'h1 << 10,  M_MDR_RD = 28'h1 << 11,
    M_IR_RD = 28'h1 << 12,   M_Y_RD = 28'h1 << 13,    M_ZLO_RD = 28'h1 << 14,
    M_ZHI_RD = 28'h1 << 15,  M_PC_RD = 28'h1 << 16,   M_HI_RD = 28'h1 << 17,
    M_LO_RD = 28'h1 << 18,   M_OUT_RD = 28'h1 << 19,  M_RIN = 28'h1 << 20,
    M_CONIN = 28'h1 << 21,   M_GRA = 28'h1 << 22,     M_GRB = 28'h1 << 23,
    M_GRC = 28'h1 << 24,     M_INCPC = 28'h1 << 25,   M_READ = 28'h1 << 26,
    M_WRITE = 28'h1 << 27;
  localparam logic [27:0] F0 = M_PC_OUT | M_MAR_RD | M_INCPC | M_ZLO_RD;
  localparam logic [4:0]  ADDOP = 5'd3;

  typedef struct packed { logic [27:0] s; logic [4:0] op; } ustep_t;
  ustep_t prog[$];

  typedef struct { logic [31:0] ir; bit con; int lat; logic [27:0] t3; string name; } vec_t;
  vec_t vecs[14];

  task automatic check_output(input string name, input logic [33:0] actual, input logic [33:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_count(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic add_step(input logic [27:0] s, input logic [4:0] op);
    ustep_t u;
    u.s = s;
    u.op = op;
    prog.push_back(u);
  endtask

  // Reference microprogram for one instruction, written as the list of
  // strobe sets the instruction should produce, fetch included.
  task automatic build_program(input logic [4:0] opc, input bit con);
    prog.delete();
    add_step(F0, 5'd0);
    add_step(M_ZLO_OUT | M_PC_RD | M_READ | M_MDR_RD, 5'd0);
    add_step(M_MDR_OUT | M_IR_RD, 5'd0);
    case (opc) inside
      [5'd3:5'd14]: begin
        add_step(M_GRB | M_R_OUT | M_Y_RD, 5'd0);
        if (opc >= 5'd12) add_step(M_C_OUT | M_ZLO_RD, opc);
        else              add_step(M_GRC | M_R_OUT | M_ZLO_RD, opc);
        add_step(M_ZLO_OUT | M_GRA | M_RIN, 5'd0);
      end
      5'd0, 5'd1, 5'd2: begin
        add_step(M_GRB | M_BAOUT | M_Y_RD, 5'd0);
        add_step(M_C_OUT | M_ZLO_RD, ADDOP);
        if (opc == 5'd1) add_step(M_ZLO_OUT | M_GRA | M_RIN, 5'd0);
        else begin
          add_step(M_ZLO_OUT | M_MAR_RD, 5'd0);
          if (opc == 5'd0) begin
            add_step(M_READ | M_MDR_RD, 5'd0);
            add_step(M_MDR_OUT | M_GRA | M_RIN, 5'd0);
          end else begin
            add_step(M_GRA | M_R_OUT | M_MDR_RD, 5'd0);
            add_step(M_WRITE, 5'd0);
          end
        end
      end
      5'd15, 5'd16: begin
        add_step(M_GRA | M_R_OUT | M_Y_RD, 5'd0);
        add_step(M_GRB | M_R_OUT | M_ZLO_RD | M_ZHI_RD, opc);
        add_step(M_ZLO_OUT | M_LO_RD, 5'd0);
        add_step(M_ZHI_OUT | M_HI_RD, 5'd0);
      end
      5'd17, 5'd18: begin
        add_step(M_GRB | M_R_OUT | M_ZLO_RD, opc);
        add_step(M_ZLO_OUT | M_GRA | M_RIN, 5'd0);
      end
      5'd19: begin
        add_step(M_GRA | M_R_OUT | M_CONIN, 5'd0);
        add_step(M_PC_OUT | M_Y_RD, 5'd0);
        add_step(M_C_OUT | M_ZLO_RD, ADDOP);
        add_step(con ? (M_ZLO_OUT | M_PC_RD) : 28'h0, 5'd0);
      end
      5'd20: add_step(M_GRA | M_R_OUT | M_PC_RD, 5'd0);
      5'd21: begin
        add_step(M_PC_OUT | M_GRB | M_RIN, 5'd0);
        add_step(M_GRA | M_R_OUT | M_PC_RD, 5'd0);
      end
      5'd22: add_step(M_IN_OUT | M_GRA | M_RIN, 5'd0);
      5'd23: add_step(M_GRA | M_R_OUT | M_OUT_RD, 5'd0);
      5'd24: add_step(M_HI_OUT | M_GRA | M_RIN, 5'd0);
      5'd25: add_step(M_LO_OUT | M_GRA | M_RIN, 5'd0);
      default: ;
    endcase
  endtask

  // Runs one instruction from T0, comparing every cycle with its microprogram.
  task automatic apply_stimulus(input logic [31:0] ir, input bit con, input int stop_on,
                                input int stop_off, input string name);
    build_program(ir[31:27], con);
    IR = ir;
    CON_ff = con;
    foreach (prog[k]) begin
      if (k == stop_on)  Stop = 1'b1;
      if (k == stop_off) Stop = 1'b0;
      check_output($sformatf("%s_step%0d", name, k), got, {1'b1, prog[k].op, prog[k].s});
      check_count("bus_onehot", int'($countones(act[9:0]) <= 1), 1);
      check_count("gr_onehot", int'($countones(act[24:22]) <= 1), 1);
      reads  += int'(Read);
      writes += int'(Write);
      @(posedge clk);
      @(negedge clk);
    end
    Stop = 1'b0;
  endtask

  task automatic apply_vector(input vec_t v);
    int cyc = 0;
    bit seen = 0;
    logic [27:0] t3 = '0;
    IR = v.ir;
    CON_ff = v.con;
    while (cyc < 12) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 3) t3 = act;
      if (act == F0 && Run) begin
        seen = 1;
        break;
      end
    end
    check_count({v.name, "_latency"}, seen ? cyc : -1, v.lat);
    if (v.lat > 3) check_output({v.name, "_T3"}, {6'd0, t3}, {6'd0, v.t3});
  endtask

  task automatic do_reset(input string name);
    clr = 1'b0;
    #1 check_output({name, "_async"}, got, '0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output({name, "_T0"}, got, {1'b1, 5'd0, F0});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] opc;
    vecs[0]  = '{32'h18918000, 1'b0, 6, M_GRB | M_R_OUT | M_Y_RD, "add"};
    vecs[1]  = '{32'h9A800004, 1'b1, 7, M_GRA | M_R_OUT | M_CONIN, "br_taken"};
    vecs[2]  = '{32'h9A800004, 1'b0, 7, M_GRA | M_R_OUT | M_CONIN, "br_not_taken"};
    vecs[3]  = '{32'hA0800000, 1'b0, 4, M_GRA | M_R_OUT | M_PC_RD, "jr"};
    vecs[4]  = '{32'hA8800000, 1'b0, 5, M_PC_OUT | M_GRB | M_RIN, "jal"};
    vecs[5]  = '{32'h78900000, 1'b0, 7, M_GRA | M_R_OUT | M_Y_RD, "mul"};
    vecs[6]  = '{32'h00800010, 1'b0, 8, M_GRB | M_BAOUT | M_Y_RD, "ld"};
    vecs[7]  = '{32'h10800010, 1'b0, 8, M_GRB | M_BAOUT | M_Y_RD, "st"};
    vecs[8]  = '{32'h88900000, 1'b0, 5, M_GRB | M_R_OUT | M_ZLO_RD, "neg"};
    vecs[9]  = '{32'hC0800000, 1'b0, 4, M_HI_OUT | M_GRA | M_RIN, "mfhi"};
    vecs[10] = '{32'hD0000000, 1'b0, 3, 28'h0, "nop"};
    vecs[11] = '{32'hF0000000, 1'b0, 3, 28'h0, "undef30"};
    vecs[12] = '{32'h60900005, 1'b0, 6, M_GRB | M_R_OUT | M_Y_RD, "addi"};
    vecs[13] = '{32'hB0800000, 1'b0, 4, M_IN_OUT | M_GRA | M_RIN, "in"};

    clr = 1'b0; Stop = 1'b0; CON_ff = 1'b0; IR = '0;
    reads = 0; writes = 0;
    repeat (2) @(negedge clk);
    check_output("reset_outputs", got, '0);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("first_fetch_T0", got, {1'b1, 5'd0, F0});

    foreach (vecs[i]) apply_vector(vecs[i]);

    apply_stimulus(32'h18918000, 1'b0, -1, -1, "add");
    apply_stimulus(32'h9A800004, 1'b1, -1, -1, "br1");
    apply_stimulus(32'h9A800004, 1'b0, -1, -1, "br0");
    reads = 0;
    apply_stimulus(32'h00800010, 1'b0, -1, -1, "ld");
    check_count("ld_read_cycles", reads, 2);
    writes = 0;
    apply_stimulus(32'h10800010, 1'b0, -1, -1, "st");
    check_count("st_write_cycles", writes, 1);

    // Abort a load in T4 and come back through RESET.
    build_program(5'd0, 1'b0);
    IR = 32'h00800010;
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("ld_abort_step%0d", k), got, {1'b1, prog[k].op, prog[k].s});
      if (k < 4) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    do_reset("ld_abort");

    apply_stimulus(32'h18918000, 1'b0, 3, 4, "add_stop_dropped");
    check_output("stop_dropped_T0", got, {1'b1, 5'd0, F0});

    repeat (60) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'd27) opc = 5'd26;
      apply_stimulus({opc, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, -1,
                     $sformatf("rand_op%0d", opc));
    end

    apply_stimulus(32'h18918000, 1'b0, 4, -1, "add_stop");
    repeat (3) begin
      check_output("stop_halt", got, '0);
      @(negedge clk);
    end
    do_reset("after_stop");

    apply_stimulus(32'hD8000000, 1'b0, -1, -1, "halt");
    repeat (100) begin
      check_output("halt_idle", got, '0);
      @(negedge clk);
    end
    do_reset("after_halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
